// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: owner FSM states and the codes
// recording which requester a pending read belongs to.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU      = 2'd1,
    ST_DMA      = 2'd2,
    ST_DMA_LOCK = 2'd3
  } arbState_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used by the arbiter for
// both DMA starvation tracking and the locked-hold duration.
module sat_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] TOP = W'(MAX);

  logic [W-1:0] r_count;

  // Clear wins over increment; the count sticks at MAX once reached.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != TOP)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between a multicycle CPU and a loader/DMA port,
// with CPU priority, DMA anti-starvation and a bounded DMA lock.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 8,
  parameter int LOCK_MAX   = 16
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic          dma_lock,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_MAX - 1);

  arbState_t     r_state;
  arbState_t     w_next;
  owner_t        r_rdOwner;
  owner_t        w_rdOwner;
  logic          r_lockBlock;
  logic          w_cpuReq;
  logic          w_lockRun;
  logic          w_lockEnd;
  logic          w_cpuGnt;
  logic          w_dmaGnt;
  logic [SW-1:0] w_starveCnt;
  logic [LW-1:0] w_lockCnt;

  sat_counter #(.MAX(STARVE_MAX), .W(SW)) u_starve (
    .clock   (clock),
    .resetn  (resetn),
    .i_clr   (w_dmaGnt),
    .i_inc   (dma_req & ~w_dmaGnt),
    .o_count (w_starveCnt)
  );

  // Counts cycles actually spent holding the lock; clears as soon as it is left.
  sat_counter #(.MAX(LOCK_MAX), .W(LW)) u_lock (
    .clock   (clock),
    .resetn  (resetn),
    .i_clr   (~w_lockRun),
    .i_inc   (w_lockRun),
    .o_count (w_lockCnt)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Grant priority: live lock, then starved DMA, then CPU, then idle-CPU DMA.
  always_comb begin
    w_cpuReq  = cpu_rd | cpu_wr;
    w_lockRun = (r_state == ST_DMA_LOCK) && dma_req && dma_lock;
    w_lockEnd = w_lockRun && (w_lockCnt == LOCK_LAST);
    w_cpuGnt  = 1'b0;
    w_dmaGnt  = 1'b0;
    w_next    = ST_IDLE;
    if (w_lockRun) begin
      w_dmaGnt = 1'b1;
    end else if (dma_req && (w_starveCnt == STARVE_TOP)) begin
      w_dmaGnt = 1'b1;
    end else if (w_cpuReq) begin
      w_cpuGnt = 1'b1;
    end else if (dma_req) begin
      w_dmaGnt = 1'b1;
    end
    if (w_cpuGnt) begin
      w_next = ST_CPU;
    end else if (w_dmaGnt) begin
      if (w_lockRun) begin
        w_next = w_lockEnd ? ST_DMA : ST_DMA_LOCK;
      end else if (dma_lock && !r_lockBlock) begin
        w_next = ST_DMA_LOCK;
      end else begin
        w_next = ST_DMA;
      end
    end
  end

  // A forced exit must not re-enter the lock until the DMA side lets go of it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_lockBlock <= 1'b0;
    end else if (!dma_lock) begin
      r_lockBlock <= 1'b0;
    end else if (w_lockEnd) begin
      r_lockBlock <= 1'b1;
    end
  end

  // Memory-side mux; everything is held at zero while reset is asserted.
  always_comb begin
    cpu_stall = 1'b0;
    dma_gnt   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    w_rdOwner = OWN_NONE;
    if (resetn) begin
      cpu_stall = w_cpuReq & w_dmaGnt;
      dma_gnt   = w_dmaGnt;
      if (w_cpuGnt) begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_wr;
        mem_re    = cpu_rd & ~cpu_wr;
        if (cpu_rd && !cpu_wr) begin
          w_rdOwner = OWN_CPU;
        end
      end else if (w_dmaGnt) begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_we;
        mem_re    = ~dma_we;
        if (!dma_we) begin
          w_rdOwner = OWN_DMA;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rdOwner <= OWN_NONE;
    end else begin
      r_rdOwner <= w_rdOwner;
    end
  end

  assign cpu_rvalid = (r_rdOwner == OWN_CPU);
  assign dma_rvalid = (r_rdOwner == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// phase, all compared against a cycle-level behavioural arbitration model.
module tb_mem_arbiter;

  localparam int AW         = 8;
  localparam int DW         = 8;
  localparam int STARVE_MAX = 8;
  localparam int LOCK_MAX   = 16;

  logic          clock = 1'b0;
  logic          resetn;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          dma_req, dma_we, dma_lock;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] tbMem  [256];
  logic [DW-1:0] refMem [256];

  // reference model state
  int            starve;
  int            lockCycles;
  bit            inLock;
  bit            lockBlocked;
  int            pendOwner;
  logic [DW-1:0] pendData;

  // last observed values, for scenario-specific checks
  logic          lastGnt, lastStall, lastWe, lastRe;
  logic          lastCpuV, lastDmaV;
  logic [DW-1:0] lastCpuD, lastDmaD;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_lock   (dma_lock),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory the arbiter drives.
  always @(posedge clock) begin
    if (mem_re) mem_rdata <= tbMem[mem_addr];
    if (mem_we) tbMem[mem_addr] <= mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Who wins this cycle: 0 none, 1 CPU, 2 DMA.
  function automatic int arbitrate();
    if (inLock && dma_req && dma_lock) return 2;
    if (dma_req && starve >= STARVE_MAX) return 2;
    if (cpu_rd || cpu_wr) return 1;
    if (dma_req) return 2;
    return 0;
  endfunction

  task automatic modelReset();
    starve      = 0;
    lockCycles  = 0;
    inLock      = 0;
    lockBlocked = 0;
    pendOwner   = 0;
    pendData    = '0;
  endtask

  // Drive one cycle of inputs, check all outputs mid-cycle, advance the model.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] ca,
                               input logic [7:0] cw, input logic dr, input logic dwe,
                               input logic dl, input logic [7:0] da, input logic [7:0] dw);
    int            own;
    logic          eWe, eRe;
    logic [7:0]    eAddr, eWd;
    bit            lockGo;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = ca; cpu_wdata = cw;
    dma_req = dr; dma_we = dwe; dma_lock = dl; dma_addr = da; dma_wdata = dw;
    @(negedge clock);
    own   = arbitrate();
    eWe   = (own == 1) ? wr : (own == 2) ? dwe : 1'b0;
    eRe   = (own == 1) ? (rd && !wr) : (own == 2) ? !dwe : 1'b0;
    eAddr = (own == 1) ? ca : (own == 2) ? da : 8'h00;
    eWd   = (own == 1) ? cw : (own == 2) ? dw : 8'h00;
    checkOutput("dma_gnt",    32'(dma_gnt),    32'(own == 2));
    checkOutput("cpu_stall",  32'(cpu_stall),  32'(own == 2 && (rd || wr)));
    checkOutput("mem_we",     32'(mem_we),     32'(eWe));
    checkOutput("mem_re",     32'(mem_re),     32'(eRe));
    checkOutput("mem_addr",   32'(mem_addr),   32'(eAddr));
    checkOutput("mem_wdata",  32'(mem_wdata),  32'(eWd));
    checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(pendOwner == 1));
    checkOutput("dma_rvalid", 32'(dma_rvalid), 32'(pendOwner == 2));
    checkOutput("cpu_rdata",  32'(cpu_rdata),  32'((pendOwner == 1) ? pendData : 8'h00));
    checkOutput("dma_rdata",  32'(dma_rdata),  32'((pendOwner == 2) ? pendData : 8'h00));
    lastGnt = dma_gnt; lastStall = cpu_stall; lastWe = mem_we; lastRe = mem_re;
    lastCpuV = cpu_rvalid; lastDmaV = dma_rvalid; lastCpuD = cpu_rdata; lastDmaD = dma_rdata;
    @(posedge clock);
    lockGo = inLock && dr && dl;
    if (eRe) begin
      pendOwner = own;
      pendData  = refMem[eAddr];
    end else begin
      pendOwner = 0;
    end
    if (eWe) refMem[eAddr] = eWd;
    if (own == 2) starve = 0;
    else if (dr) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
    if (lockGo) begin
      lockCycles++;
      if (lockCycles == LOCK_MAX) begin
        inLock      = 0;
        lockBlocked = 1;
      end
    end else begin
      inLock     = (own == 2) && dl && !lockBlocked;
      lockCycles = 0;
    end
    if (!dl) lockBlocked = 0;
    #1;
  endtask

  // Assert reset (optionally with DMA still requesting) and check outputs are all zero.
  task automatic doReset(input logic holdDma);
    resetn  = 1'b0;
    cpu_rd  = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = holdDma; dma_we = 1'b0; dma_lock = holdDma; dma_addr = 8'h05; dma_wdata = '0;
    modelReset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checkOutput("rst_cpu_stall",  32'(cpu_stall),  32'h0);
      checkOutput("rst_dma_gnt",    32'(dma_gnt),    32'h0);
      checkOutput("rst_mem_we",     32'(mem_we),     32'h0);
      checkOutput("rst_mem_re",     32'(mem_re),     32'h0);
      checkOutput("rst_mem_addr",   32'(mem_addr),   32'h0);
      checkOutput("rst_mem_wdata",  32'(mem_wdata),  32'h0);
      checkOutput("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
      checkOutput("rst_dma_rvalid", 32'(dma_rvalid), 32'h0);
      checkOutput("rst_cpu_rdata",  32'(cpu_rdata),  32'h0);
      checkOutput("rst_dma_rdata",  32'(dma_rdata),  32'h0);
      @(posedge clock);
      #1;
    end
    dma_req = 1'b0; dma_lock = 1'b0;
    resetn  = 1'b1;
  endtask

  logic [1:0] lockTailGnt   [5];
  logic       lockTailStall [5];

  initial begin
    for (int i = 0; i < 256; i++) begin
      tbMem[i]  = 8'(i) ^ 8'h5A;
      refMem[i] = 8'(i) ^ 8'h5A;
    end
    mem_rdata = '0;
    #1;
    doReset(1'b0);

    $display("[TB] CPU read of 0x10");
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("cpu_rd_re",    32'(lastRe),    32'h1);
    checkOutput("cpu_rd_stall", 32'(lastStall), 32'h0);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("cpu_rd_valid", 32'(lastCpuV), 32'h1);
    checkOutput("cpu_rd_data",  32'(lastCpuD), 32'h4A);

    $display("[TB] starvation: both requesting every cycle");
    doReset(1'b0);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      checkOutput($sformatf("starve_gnt_c%0d", k + 1),   32'(lastGnt),   32'(k == 8));
      checkOutput($sformatf("starve_stall_c%0d", k + 1), 32'(lastStall), 32'(k == 8));
    end

    $display("[TB] DMA write then CPU read-back");
    doReset(1'b0);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h20, 8'hA5);
    checkOutput("dma_wr_gnt", 32'(lastGnt), 32'h1);
    checkOutput("dma_wr_we",  32'(lastWe),  32'h1);
    applyStimulus(1, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("readback_valid", 32'(lastCpuV), 32'h1);
    checkOutput("readback_data",  32'(lastCpuD), 32'hA5);

    $display("[TB] DMA lock held 20 cycles with CPU requesting");
    doReset(1'b0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(k >= 1, 0, 8'h03, 8'h00, 1, 0, 1, 8'h04, 8'h00);
      checkOutput($sformatf("lock_gnt_k%0d", k),   32'(lastGnt),   32'(k <= 16));
      checkOutput($sformatf("lock_stall_k%0d", k), 32'(lastStall), 32'(k >= 1 && k <= 16));
    end
    // lock still asserted: plain DMA grant, CPU wins next; re-arms only after a drop
    lockTailGnt   = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd1};
    lockTailStall = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h04, 8'h00);
    checkOutput("relock_t0_gnt", 32'(lastGnt), 32'(lockTailGnt[0]));
    applyStimulus(1, 0, 8'h03, 8'h00, 1, 0, 1, 8'h04, 8'h00);
    checkOutput("relock_t1_gnt",   32'(lastGnt),   32'(lockTailGnt[1]));
    checkOutput("relock_t1_stall", 32'(lastStall), 32'(lockTailStall[1]));
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h04, 8'h00);
    checkOutput("relock_t2_gnt", 32'(lastGnt), 32'(lockTailGnt[2]));
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h04, 8'h00);
    checkOutput("relock_t3_gnt", 32'(lastGnt), 32'(lockTailGnt[3]));
    applyStimulus(1, 0, 8'h03, 8'h00, 1, 0, 1, 8'h04, 8'h00);
    checkOutput("relock_t4_gnt",   32'(lastGnt),   32'(lockTailGnt[4]));
    checkOutput("relock_t4_stall", 32'(lastStall), 32'(lockTailStall[4]));

    $display("[TB] reset during an in-flight DMA read");
    doReset(1'b0);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h05, 8'h00);
    checkOutput("inflight_gnt", 32'(lastGnt), 32'h1);
    doReset(1'b1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      checkOutput($sformatf("post_rst_dma_rvalid_%0d", k), 32'(lastDmaV), 32'h0);
    end

    $display("[TB] back-to-back CPU read then DMA read");
    applyStimulus(1, 0, 8'h30, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h31, 8'h00);
    checkOutput("b2b_cpu_valid", 32'(lastCpuV), 32'h1);
    checkOutput("b2b_cpu_data",  32'(lastCpuD), 32'h6A);
    checkOutput("b2b_dma_idle",  32'(lastDmaV), 32'h0);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("b2b_dma_valid", 32'(lastDmaV), 32'h1);
    checkOutput("b2b_dma_data",  32'(lastDmaD), 32'h6B);
    checkOutput("b2b_cpu_idle",  32'(lastCpuV), 32'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) doReset($urandom_range(0, 1) == 1);
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                    8'($urandom_range(0, 15)), 8'($urandom),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 3) != 0,
                    8'($urandom_range(0, 15)), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: AW, default 8, address width; DW, default 8, data width; STARVE_MAX, default 8, maximum consecutive cycles a pending DMA request may be denied; LOCK_MAX, default 16, maximum cycles of a locked DMA hold.
REQ-002 SHALL have ports:
 clock  in  1  sole clock, rising edge.
 resetn  in  1  asynchronous, active-low reset.
 cpu_rd  in  1  CPU FSM memory read request (MemRead).
 cpu_wr  in  1  CPU FSM memory write request (MemWrite).
 cpu_addr  in  AW  CPU address.
 cpu_wdata  in  DW  CPU write data.
 cpu_stall  out  1  freeze CPU FSM state and PC this cycle.
 cpu_rdata  out  DW  read data to MDR/IR.
 cpu_rvalid  out  1  cpu_rdata valid this cycle.
 dma_req  in  1  loader/DMA access request.
 dma_we  in  1  1 = write, 0 = read.
 dma_lock  in  1  hold ownership across consecutive DMA accesses.
 dma_addr  in  AW  DMA address.
 dma_wdata  in  DW  DMA write data.
 dma_gnt  out  1  DMA access accepted this cycle.
 dma_rdata  out  DW  DMA read data.
 dma_rvalid  out  1  dma_rdata valid this cycle.
 mem_addr  out  AW  memory address.
 mem_wdata  out  DW  memory write data.
 mem_we  out  1  memory write strobe.
 mem_re  out  1  memory read strobe; mem_rdata returns exactly 1 cycle later.
 mem_rdata  in  DW  synchronous-read memory data.

Function
REQ-003 SHALL grant at most one requester per cycle; mem_* SHALL be driven from the granted requester only, with mem_we = mem_re = 0 when no grant is given.
REQ-004 SHALL use the states IDLE, CPU, DMA and DMA_LOCK, held in a registered owner FSM.
REQ-005 SHALL give the CPU priority by default; a CPU request (cpu_rd|cpu_wr) is granted in the same cycle with cpu_stall = 0.
REQ-006 SHALL keep a starve counter that increments each cycle dma_req=1 and is denied; the counter SHALL saturate at STARVE_MAX and clear on dma_gnt.
REQ-007 SHALL grant DMA over a simultaneous CPU request when starve counter == STARVE_MAX; in that case cpu_stall = 1 and the CPU request SHALL be granted in the next non-DMA cycle.
REQ-008 SHALL grant DMA whenever dma_req=1 and no CPU request is present.
REQ-009 SHALL move to DMA_LOCK on a DMA grant with dma_lock=1; in DMA_LOCK, DMA keeps priority and cpu_stall = 1 for any CPU request.
REQ-010 SHALL leave DMA_LOCK when dma_lock=0 or dma_req=0, or after LOCK_MAX cycles in DMA_LOCK; after a forced exit the CPU SHALL win the next cycle if it is requesting, and the lock SHALL be re-armed only after dma_lock deasserts.
REQ-011 SHALL register the owner of each read; one cycle later it SHALL route mem_rdata to the matching rdata and pulse that rvalid for 1 cycle, independent of the current grant.
REQ-012 SHALL treat cpu_rd and cpu_wr asserted together as a write.
REQ-013 SHALL give writes zero return latency: no rvalid is produced for a write.

Reset
REQ-014 SHALL, while resetn=0, set the state to IDLE, clear the starve counter, the lock counter and the read-owner pipeline, and drive every output to 0.
REQ-015 SHALL discard any read in flight when reset asserts mid-operation; no rvalid SHALL appear after reset release without a new grant.

Structure
REQ-016 SHALL take the state encoding and owner codes (NONE, CPU, DMA) from a shared package mem_arb_pkg.
REQ-017 SHALL implement the saturating starve/lock counting in one sub-module, sat_counter, instantiated twice.

Verification
REQ-018 Bench SHALL cover: CPU read of addr 0x10 alone -> mem_re=1, cpu_stall=0, cpu_rvalid one cycle later with memory contents.
REQ-019 Bench SHALL cover: CPU and DMA requesting every cycle, STARVE_MAX=8 -> dma_gnt on cycle 9, cpu_stall=1 in that cycle only.
REQ-020 Bench SHALL cover: DMA write 0xA5 to 0x20 with CPU idle, then CPU read of 0x20 -> cpu_rdata=0xA5.
REQ-021 Bench SHALL cover: dma_lock held for 20 cycles with CPU requesting -> forced exit after 16 cycles in DMA_LOCK, CPU granted on the next cycle, no re-lock until dma_lock drops.
REQ-022 Bench SHALL cover: DMA read granted and resetn pulsed low the next cycle -> no dma_rvalid, all outputs 0.
REQ-023 Bench SHALL cover: a back-to-back CPU read then DMA read -> rvalid pulses are routed to the correct requester in consecutive cycles.
